cla_addsub_pipe: RTL

//  Pipelined WIDTH-bit adder/subtractor; computes A+B or A-B one SLICE-bit slice per stage.

---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla_slice16.sv | 58 +++++
 rtl/cla_addsub_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the pipelined carry-lookahead adder/subtractor.
// Operand fields in stage_t are sized for the widest supported datapath (WIDTH <= WIDTH_MAX).
package cla_pkg;

   localparam int SLICE_W   = 16;
   localparam int WIDTH_MAX = 64;

   typedef logic [SLICE_W-1:0] slice_t;

   typedef struct packed {
      logic                 v;
      logic                 sub;
      logic                 carry;
      logic [WIDTH_MAX-1:0] a_hi;
      logic [WIDTH_MAX-1:0] b_hi;
      logic [WIDTH_MAX-1:0] res_lo;
   } stage_t;

   function automatic int nst(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/cla_slice16.sv
// Combinational 16-bit carry-lookahead slice: 4-bit group generate/propagate with a
// second lookahead level across the four groups.
module cla_slice16
   import cla_pkg::*;
(
   input  slice_t a_i,
   input  slice_t b_i,
   input  logic   cin_i,
   output slice_t s_o,
   output logic   cout_o,
   output logic   c_msb_in_o
);

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [3:0]         gg;
   logic [3:0]         gp;
   logic [4:0]         cg;
   logic [SLICE_W:0]   c;

   always_comb begin
      g  = a_i & b_i;
      p  = a_i ^ b_i;
      gg = '0;
      gp = '0;
      for (int j = 0; j < 4; j++) begin
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end

      // Group carries resolved in parallel from cin and the group P/G terms
      cg[0] = cin_i;
      cg[1] = gg[0] | (gp[0] & cin_i);
      cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
      cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & cin_i);
      cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);

      c = '0;
      for (int j = 0; j < 4; j++) begin
         c[4*j] = cg[j];
         for (int i = 0; i < 3; i++) begin
            c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
         end
      end
      c[SLICE_W] = cg[4];

      s_o        = p ^ c[SLICE_W-1:0];
      cout_o     = c[SLICE_W];
      c_msb_in_o = c[SLICE_W-1];
   end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined WIDTH-bit add/sub: one 16-bit CLA slice per stage, carry registered between
// stages, operands skewed forward and results deskewed, valid/ready on both sides.
module cla_addsub_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sub,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int NST = nst(WIDTH);

   stage_t         st_q [NST];
   stage_t         st_d [NST];
   logic           c_msb [NST];
   logic [NST-1:0] src_v;
   logic [NST-1:0] adv;
   logic [NST-1:0] load;
   logic           ovf_q;
   logic           zero_q;
   logic           ovf_d;
   logic           zero_d;

   for (genvar k = 0; k < NST; k++) begin : g_stage
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] r_src;
      logic [WIDTH-1:0] r_new;
      logic             c_src;
      logic             sub_src;
      logic             co;
      slice_t           s;

      // Stage 0 takes the ports (B inverted for subtract); later stages take the skewed copy
      if (k == 0) begin : g_first
         assign a_src    = in_a;
         assign b_src    = in_sub ? ~in_b : in_b;
         assign c_src    = in_sub;
         assign sub_src  = in_sub;
         assign r_src    = '0;
         assign src_v[k] = in_valid;
      end else begin : g_next
         assign a_src    = st_q[k-1].a_hi[WIDTH-1:0];
         assign b_src    = st_q[k-1].b_hi[WIDTH-1:0];
         assign c_src    = st_q[k-1].carry;
         assign sub_src  = st_q[k-1].sub;
         assign r_src    = st_q[k-1].res_lo[WIDTH-1:0];
         assign src_v[k] = st_q[k-1].v;
      end

      cla_slice16 u_slice (
         .a_i        (a_src[k*SLICE +: SLICE]),
         .b_i        (b_src[k*SLICE +: SLICE]),
         .cin_i      (c_src),
         .s_o        (s),
         .cout_o     (co),
         .c_msb_in_o (c_msb[k])
      );

      always_comb begin
         r_new                   = r_src;
         r_new[k*SLICE +: SLICE] = s;
      end

      assign st_d[k] = '{v:      1'b1,
                         sub:    sub_src,
                         carry:  co,
                         a_hi:   WIDTH_MAX'(a_src),
                         b_hi:   WIDTH_MAX'(b_src),
                         res_lo: WIDTH_MAX'(r_new)};
   end

   assign ovf_d  = c_msb[NST-1] ^ st_d[NST-1].carry;
   assign zero_d = ~|st_d[NST-1].res_lo[WIDTH-1:0];

   // Advance chain runs from the output back to the input in one cycle
   always_comb begin
      adv          = '0;
      adv[NST-1]   = st_q[NST-1].v && out_ready;
      for (int k = NST-2; k >= 0; k--) begin
         adv[k] = st_q[k].v && (!st_q[k+1].v || adv[k+1]);
      end
      for (int k = 0; k < NST; k++) begin
         load[k] = !st_q[k].v || adv[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NST; k++) begin
            st_q[k] <= '0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         for (int k = 0; k < NST; k++) begin
            if (load[k]) begin
               if (src_v[k]) begin
                  st_q[k] <= st_d[k];
               end else begin
                  st_q[k].v <= 1'b0;
               end
            end
         end
         if (load[NST-1] && src_v[NST-1]) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
         end
      end
   end

   assign in_ready  = load[0];
   assign out_valid = st_q[NST-1].v;
   assign out_res   = st_q[NST-1].res_lo[WIDTH-1:0];
   assign out_cout  = st_q[NST-1].carry;
   assign out_ovf   = ovf_q;
   assign out_zero  = zero_q;

endmodule
